// File: rtl/fu_mult_pipe_pkg.sv
// Shared ALU function encoding and multiply-pipeline types/constants.
// Used by fu_mult_pipe and its bench.
package fu_mult_pipe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLT    = 5'd2,
        ALU_SLTU   = 5'd3,
        ALU_AND    = 5'd4,
        ALU_OR     = 5'd5,
        ALU_XOR    = 5'd6,
        ALU_SLL    = 5'd7,
        ALU_SRL    = 5'd8,
        ALU_SRA    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13
    } alu_func_e;

    localparam int MULT_XLEN  = 32;
    localparam int MULT_TAG_W = 6;

    localparam logic [31:0] MULT_BAD_RESULT = 32'hfacebeec;

    // Stage register layout at the default configuration; the pipeline
    // declares the same layout locally against its own parameters.
    typedef struct packed {
        logic                     valid;
        alu_func_e                func;
        logic [MULT_TAG_W-1:0]    tag;
        logic [2*MULT_XLEN-1:0]   opa_ext;
        logic [2*MULT_XLEN-1:0]   opb_ext;
        logic [2*MULT_XLEN-1:0]   acc;
    } mult_stage_t;

endpackage

// File: rtl/fu_mult_stage.sv
// One combinational step of the multiply pipeline: adds the partial product
// of opa_ext and one CW-bit multiplier chunk, shifted into place, to acc_in.
module fu_mult_stage #(
    parameter int XLEN = 32,
    parameter int CW   = 16,
    parameter int IDX  = 0
) (
    input  logic [2*XLEN-1:0] opa_ext,
    input  logic [CW-1:0]     opb_chunk,
    input  logic [2*XLEN-1:0] acc_in,
    output logic [2*XLEN-1:0] acc_out
);

    logic [2*XLEN-1:0] partial;

    // Everything wraps mod 2^(2*XLEN), so truncating the product is exact.
    assign partial = opa_ext * (2*XLEN)'(opb_chunk);
    assign acc_out = acc_in + (partial << (IDX * CW));

endmodule

// File: rtl/fu_mult_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with global stall and squash.
// Optional perf counters are enabled by defining FU_MULT_PIPE_PERF_EN.
module fu_mult_pipe
    import fu_mult_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  logic [4:0]       func,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             squash,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
`ifdef FU_MULT_PIPE_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stall
`endif
);

    localparam int WW = 2 * XLEN;
    localparam int CW = WW / STAGES;

    typedef struct packed {
        logic             valid;
        alu_func_e        func;
        logic [TAG_W-1:0] tag;
        logic [WW-1:0]    opa_ext;
        logic [WW-1:0]    opb_ext;
        logic [WW-1:0]    acc;
    } stage_t;

    stage_t           stage_q [STAGES];
    stage_t           stage_d [STAGES];
    logic [WW-1:0]    acc_next [STAGES];
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    alu_func_e     in_func;
    logic          sign_a, sign_b;
    logic [WW-1:0] opa_ext, opb_ext;
    logic          advance, accept;

    assign in_func  = alu_func_e'(func);
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance && !squash;

    assign sign_a  = (in_func == ALU_MUL) || (in_func == ALU_MULH) || (in_func == ALU_MULHSU);
    assign sign_b  = (in_func == ALU_MUL) || (in_func == ALU_MULH);
    assign opa_ext = {{XLEN{sign_a & opa[XLEN-1]}}, opa};
    assign opb_ext = {{XLEN{sign_b & opb[XLEN-1]}}, opb};

    function automatic logic [XLEN-1:0] sel_result(alu_func_e f, logic [WW-1:0] acc);
        case (f)
            ALU_MUL:                       return acc[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: return acc[WW-1:XLEN];
            default:                       return XLEN'(MULT_BAD_RESULT);
        endcase
    endfunction

    // Stage 0 works directly on the freshly extended operands; later
    // stages continue from the previous stage register.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                fu_mult_stage #(.XLEN(XLEN), .CW(CW), .IDX(gi)) u_stage (
                    .opa_ext   (opa_ext),
                    .opb_chunk (opb_ext[gi*CW +: CW]),
                    .acc_in    ({WW{1'b0}}),
                    .acc_out   (acc_next[gi])
                );
            end else begin : g_rest
                fu_mult_stage #(.XLEN(XLEN), .CW(CW), .IDX(gi)) u_stage (
                    .opa_ext   (stage_q[gi-1].opa_ext),
                    .opb_chunk (stage_q[gi-1].opb_ext[gi*CW +: CW]),
                    .acc_in    (stage_q[gi-1].acc),
                    .acc_out   (acc_next[gi])
                );
            end
        end
    endgenerate

    always_comb begin
        stage_d     = stage_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;
        if (squash) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_d[k].valid = 1'b0;
            end
            out_valid_d = 1'b0;
        end else if (advance) begin
            stage_d[0].valid   = accept;
            stage_d[0].func    = in_func;
            stage_d[0].tag     = in_tag;
            stage_d[0].opa_ext = opa_ext;
            stage_d[0].opb_ext = opb_ext;
            stage_d[0].acc     = acc_next[0];
            for (int k = 1; k < STAGES; k++) begin
                stage_d[k]     = stage_q[k-1];
                stage_d[k].acc = acc_next[k];
            end
            out_valid_d = stage_q[STAGES-1].valid;
            // Keep the visible result/tag from churning on bubbles.
            if (stage_q[STAGES-1].valid) begin
                result_d  = sel_result(stage_q[STAGES-1].func, stage_q[STAGES-1].acc);
                out_tag_d = stage_q[STAGES-1].tag;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else begin
            stage_q     <= stage_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;

`ifdef FU_MULT_PIPE_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(accept);
        perf_stall_d  = perf_stall_q + 32'(out_valid_q && !out_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
